trig_rate_scaler: RTL
=====================

# trig_rate_scaler

Per-second trigger rate and dead-time scaler on the 133 MHz domain. Consumes the `usec_133m` and `sec_133m` single-cycle tick strobes from the board timer, plus the accepted-trigger and busy signals. It accumulates trigger counts, vetoed-trigger counts and busy time in microseconds over each one-second window. At every second boundary it latches the totals into stable output registers for slow-control readout, and it maintains a free-running uptime seconds counter.

## Interface
Parameters:
- `CNT_W`, 24: width of the trigger and veto counters and their latched outputs.
- `BUSY_W`, 20: width of the busy-microsecond counter and its latched output (1,000,000 fits in 20 bits).

Ports:
- `clk_133m` input 1: sole clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `usec_133m` input 1: one-cycle strobe, once per microsecond.
- `sec_133m` input 1: one-cycle strobe, once per second.
- `trig_in` input 1: trigger signal. The block counts rising edges, not high cycles.
- `busy` input 1: readout-busy level.
- `trig_rate` output CNT_W: trigger edges in the last complete window.
- `veto_rate` output CNT_W: trigger edges seen while `busy`=1 in the last complete window.
- `busy_us` output BUSY_W: count of `usec_133m` strobes with `busy`=1 in the last complete window.
- `uptime_sec` output 32: number of `sec_133m` strobes since reset.
- `rate_upd` output 1: one-cycle pulse, high in the cycle the latched outputs change.
- `rate_valid` output 1: level; high once a complete window has been latched.

## Operation
- Edge detect: register `trig_in` into `trig_d`. A trigger event is `trig_in & ~trig_d`. A veto event is a trigger event with `busy`=1 in the same cycle.
- Running counters:
  - `trig_acc` and `veto_acc` are CNT_W wide. `busy_acc` is BUSY_W wide. Each increments by 1 per qualifying event.
  - All counters saturate at all-ones and never wrap.
- Window close happens in any cycle with `sec_133m`=1:
  - Load `trig_rate`, `veto_rate` and `busy_us` from their accumulators, including any event occurring in that same cycle. Saturation still applies.
  - Restart each accumulator at 0.
  - Increment `uptime_sec`. It wraps modulo 2^32.
  - Assert `rate_upd` in the next cycle.
- Validity state machine, 3 states:
  - `PARTIAL`: entered at reset. The first window is partial.
  - On the first `sec_133m`, go to `FIRST`. That window is latched, but `rate_valid` stays 0.
  - On the second `sec_133m`, go to `RUN`. `rate_valid` becomes 1 with that update.
  - `RUN` holds until reset.
- Outputs hold their values between window closes.
- Simultaneous events:
  - `usec_133m` and `sec_133m` in the same cycle with `busy`=1: the microsecond is counted in the closing window.
  - A trigger edge in the `sec_133m` cycle is counted in the closing window.
- Reset mid-window discards the accumulators. No partial latch occurs.

## Timing
- Reset values:
  - `trig_rate`, `veto_rate`, `busy_us`, `uptime_sec` are 0.
  - `rate_upd` and `rate_valid` are 0.
  - State is `PARTIAL`. `trig_d` is 0.
- If `sec_133m` is high in cycle N:
  - The new outputs are visible from cycle N+1.
  - `rate_upd`=1 in cycle N+1 only.
  - `rate_valid` rises in N+1 on the second window close.
- Trigger edges are counted one cycle after `trig_in` rises. The minimum spacing between resolvable triggers is 2 cycles (high then low).
- Inputs are already synchronous to `clk_133m`. The block does no CDC.

## Test plan
- **Reset and idle:** assert `rst` 4 cycles; all outputs 0 while it is held; then 3 `sec_133m` strobes with no triggers. Required: `uptime_sec`=3, rates=0, `rate_upd` pulses 3 times, `rate_valid` rises after the 2nd strobe.
- **Basic counting:** 100 trigger edges, 40 of them during `busy`=1, and 500 `usec_133m` strobes with `busy`=1, then `sec_133m`. Required: next cycle `trig_rate`=100, `veto_rate`=40, `busy_us`=500; the following window restarts from 0.
- **Boundary coincidence:** a trigger edge with `busy`=1, `usec_133m` and `sec_133m` all in the same cycle. Required: the event is in the latched values (+1 each); the new window starts at 0.
- **Level trigger:** `trig_in` held high for 50 cycles. Required: counts as 1 trigger.
- **Saturation:** with CNT_W=4, 20 trigger edges in one window. Required: `trig_rate`=15.
- **Reset mid-window:** 7 trigger edges, then `rst`, then 3 edges, then `sec_133m`. Required: `trig_rate`=3, `uptime_sec`=1, `rate_valid`=0.

Source files
------------

// File: rtl/trig_rate_scaler.sv
// Per-second trigger, veto and busy-time scaler with uptime counter.
// Totals are latched at each second strobe; rate_valid qualifies them after the first full window.
module trig_rate_scaler #(
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned BUSY_W = 20
) (
  input  logic              clk_133m,
  input  logic              rst,
  input  logic              usec_133m,
  input  logic              sec_133m,
  input  logic              trig_in,
  input  logic              busy,
  output logic [CNT_W-1:0]  trig_rate,
  output logic [CNT_W-1:0]  veto_rate,
  output logic [BUSY_W-1:0] busy_us,
  output logic [31:0]       uptime_sec,
  output logic              rate_upd,
  output logic              rate_valid
);

  localparam int unsigned UP_W = 32;

  typedef enum logic [1:0] {
    S_PARTIAL = 2'd0,
    S_FIRST   = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              trig_d;
  logic              trig_ev, veto_ev, us_ev;
  logic [CNT_W-1:0]  trig_acc, veto_acc, trig_nxt, veto_nxt;
  logic [BUSY_W-1:0] busy_acc, busy_nxt;

  assign trig_ev = trig_in & ~trig_d;
  assign veto_ev = trig_ev & busy;
  assign us_ev   = usec_133m & busy;

  // Saturating next values; they include the current cycle's event so a close captures it.
  always_comb begin
    trig_nxt = trig_acc;
    veto_nxt = veto_acc;
    busy_nxt = busy_acc;
    if (trig_ev && !(&trig_acc)) trig_nxt = trig_acc + CNT_W'(1);
    if (veto_ev && !(&veto_acc)) veto_nxt = veto_acc + CNT_W'(1);
    if (us_ev && !(&busy_acc))   busy_nxt = busy_acc + BUSY_W'(1);
  end

  // Validity state: partial first window, then first full window, then running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PARTIAL: if (sec_133m) state_d = S_FIRST;
      S_FIRST:   if (sec_133m) state_d = S_RUN;
      S_RUN:     state_d = S_RUN;
      default:   state_d = S_PARTIAL;
    endcase
  end

  always_ff @(posedge clk_133m) begin
    if (rst) begin
      state_q <= S_PARTIAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_133m) begin
    if (rst) begin
      trig_d     <= 1'b0;
      trig_acc   <= '0;
      veto_acc   <= '0;
      busy_acc   <= '0;
      trig_rate  <= '0;
      veto_rate  <= '0;
      busy_us    <= '0;
      uptime_sec <= '0;
      rate_upd   <= 1'b0;
      rate_valid <= 1'b0;
    end else begin
      trig_d     <= trig_in;
      rate_upd   <= sec_133m;
      rate_valid <= (state_d == S_RUN);
      if (sec_133m) begin
        trig_rate  <= trig_nxt;
        veto_rate  <= veto_nxt;
        busy_us    <= busy_nxt;
        uptime_sec <= uptime_sec + UP_W'(1);
        trig_acc   <= '0;
        veto_acc   <= '0;
        busy_acc   <= '0;
      end else begin
        trig_acc <= trig_nxt;
        veto_acc <= veto_nxt;
        busy_acc <= busy_nxt;
      end
    end
  end

endmodule
